alu_exec_unit: RTL and testbench

//  Execute stage for the multi-cycle CPU. Merges ALU-control decode (aluop+funct -> 3-bit ctrl)

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_exec_unit_mdu.sv | 137 +++++++++++++
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU control codes, aluop/funct fields,
// the multiply/divide FSM state and the decoded operation class.
package alu_pkg;

    localparam logic [2:0] CTRL_AND  = 3'b000;
    localparam logic [2:0] CTRL_OR   = 3'b001;
    localparam logic [2:0] CTRL_SLT  = 3'b011;
    localparam logic [2:0] CTRL_ADD  = 3'b100;
    localparam logic [2:0] CTRL_ADDU = 3'b101;
    localparam logic [2:0] CTRL_SUB  = 3'b110;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } mdu_state_t;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_MFHI,
        OP_MFLO,
        OP_MDU,
        OP_DIV0,
        OP_ILLEGAL
    } op_kind_t;

endpackage

// File: rtl/alu_exec_unit_mdu.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes, sign fix-up in FIX.
// The divider datapath exists only when ALU_DIV_EN is defined.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t state, state_next;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               neg_res;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] product;

`ifdef ALU_DIV_EN
    logic               neg_a;
    logic               div_mode;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
`else
    logic               unused_is_div;
    assign unused_is_div = is_div;
`endif

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ITER;
            ITER:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mul_sum = {1'b0, acc};
        if (mq[0]) begin
            mul_sum = {1'b0, acc} + {1'b0, mcand};
        end
    end

`ifdef ALU_DIV_EN
    // Restoring step: the remainder difference is exact in WIDTH bits whenever it is kept.
    always_comb begin
        div_shift = {acc, mq[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift[WIDTH-1:0] - mcand;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mq       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
`ifdef ALU_DIV_EN
            neg_a    <= 1'b0;
            div_mode <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            acc      <= '0;
            mq       <= mag_a;
            mcand    <= mag_b;
            cnt      <= CW'(WIDTH - 1);
            neg_res  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_DIV_EN
            neg_a    <= is_signed & a[WIDTH-1];
            div_mode <= is_div;
`endif
        end else if (state == ITER) begin
            cnt <= cnt - 1'b1;
`ifdef ALU_DIV_EN
            if (div_mode) begin
                acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], div_ge};
            end else
`endif
            begin
                acc <= mul_sum[WIDTH:1];
                mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
        end
    end

    // Quotient follows the operand signs, remainder follows the dividend.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == FIX);
        product = {acc, mq};
        if (neg_res) begin
            product = -product;
        end
        hi = product[2*WIDTH-1:WIDTH];
        lo = product[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (div_mode) begin
            lo = neg_res ? -mq : mq;
            hi = neg_a ? -acc : acc;
        end
`endif
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: aluop/funct decode, single-cycle ALU, HI/LO and the mult/div handshake.
// Define ALU_DIV_EN to include div/divu; otherwise those functs decode as illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             div_zero
);

    logic [2:0]       ctrl;
    op_kind_t         kind;
    logic             accept;
    logic             mdu_start;
    logic             mdu_busy;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;

    assign accept    = in_valid & in_ready;
    assign in_ready  = ~mdu_busy;
    assign mdu_start = accept && (kind == OP_MDU);
    assign sum       = a + b;
    assign diff      = a - b;

    always_comb begin
        ctrl = CTRL_ADD;
        kind = OP_ALU;
        case (aluop)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD:   ctrl = CTRL_ADD;
                    FUNCT_ADDU:  ctrl = CTRL_ADDU;
                    FUNCT_SUB:   ctrl = CTRL_SUB;
                    FUNCT_AND:   ctrl = CTRL_AND;
                    FUNCT_OR:    ctrl = CTRL_OR;
                    FUNCT_SLT:   ctrl = CTRL_SLT;
                    FUNCT_MFHI:  kind = OP_MFHI;
                    FUNCT_MFLO:  kind = OP_MFLO;
                    FUNCT_MULT,
                    FUNCT_MULTU: kind = OP_MDU;
`ifdef ALU_DIV_EN
                    FUNCT_DIV,
                    FUNCT_DIVU:  kind = (b == '0) ? OP_DIV0 : OP_MDU;
`endif
                    default:     kind = OP_ILLEGAL;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (kind)
            OP_ALU: begin
                case (ctrl)
                    CTRL_AND:  alu_res = a & b;
                    CTRL_OR:   alu_res = a | b;
                    CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    CTRL_ADDU: alu_res = sum;
                    CTRL_ADD: begin
                        alu_res = sum;
                        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                    end
                    CTRL_SUB: begin
                        alu_res = diff;
                        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                    end
                    default:   alu_res = '0;
                endcase
            end
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_DIV0: alu_res = '1;
            default: alu_res = '0;
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .start    (mdu_start),
        .is_signed(~funct[0]),
        .is_div   (funct[1]),
        .a        (a),
        .b        (b),
        .busy     (mdu_busy),
        .done     (mdu_done),
        .hi       (mdu_hi),
        .lo       (mdu_lo)
    );

`ifdef ALU_DIV_EN
    logic div_zero_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // Flags move only together with out_valid; otherwise they hold the last completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef ALU_DIV_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (accept && kind != OP_MDU) begin
                out_valid  <= 1'b1;
                result     <= alu_res;
                zero       <= (alu_res == '0);
                overflow   <= alu_ov;
                illegal    <= (kind == OP_ILLEGAL);
`ifdef ALU_DIV_EN
                div_zero_q <= (kind == OP_DIV0);
                if (kind == OP_DIV0) begin
                    hi_q <= a;
                    lo_q <= '1;
                end
`endif
            end else if (mdu_done) begin
                out_valid  <= 1'b1;
                result     <= mdu_lo;
                zero       <= (mdu_lo == '0);
                overflow   <= 1'b0;
                illegal    <= 1'b0;
                hi_q       <= mdu_hi;
                lo_q       <= mdu_lo;
`ifdef ALU_DIV_EN
                div_zero_q <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32): ALU ops, flags, mult latency, HI/LO,
// div or its illegal decode depending on ALU_DIV_EN, and reset during a multiply.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic        div_zero;

    int total;
    int passed;
    int edges;
    bit sawReady;
    bit sawLate;

    alu_exec_unit #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluop    (aluop),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Called at a falling edge; the op is accepted on the next rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        aluop    = op;
        funct    = fn;
        a        = x;
        b        = y;
    endtask

    task automatic waitCompletion(output int n, output bit readySeen);
        readySeen = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 60) begin
            if (in_ready !== 1'b0) readySeen = 1'b1;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        aluop    = 2'b00;
        funct    = 6'b000000;
        a        = 32'h0;
        b        = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset zero", zero, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset illegal", illegal, 0);
        checkOutput("reset div_zero", div_zero, 0);

        applyStimulus(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("add ovf out_valid", out_valid, 1);
        checkOutput("add ovf result", result, 32'h80000000);
        checkOutput("add ovf overflow", overflow, 1);
        checkOutput("add ovf zero", zero, 0);

        applyStimulus(2'b10, 6'b100010, 32'd5, 32'd5);
        @(negedge clk);
        checkOutput("sub 5-5 out_valid", out_valid, 1);
        checkOutput("sub 5-5 result", result, 0);
        checkOutput("sub 5-5 zero", zero, 1);
        checkOutput("sub 5-5 overflow", overflow, 0);
        checkOutput("b2b in_ready", in_ready, 1);
        applyStimulus(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("slt out_valid", out_valid, 1);
        checkOutput("slt result", result, 1);
        checkOutput("slt zero", zero, 0);
        @(negedge clk);
        checkOutput("idle out_valid", out_valid, 0);
        checkOutput("idle result held", result, 1);

        applyStimulus(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h00000001);
        @(negedge clk);
        checkOutput("addu result", result, 32'h80000000);
        checkOutput("addu overflow", overflow, 0);
        applyStimulus(2'b01, 6'b000000, 32'h80000000, 32'h00000001);
        @(negedge clk);
        checkOutput("aluop01 sub result", result, 32'h7FFFFFFF);
        checkOutput("aluop01 sub overflow", overflow, 1);
        applyStimulus(2'b00, 6'b111111, 32'd3, 32'd4);
        @(negedge clk);
        checkOutput("aluop00 add result", result, 32'd7);
        checkOutput("aluop00 add overflow", overflow, 0);
        applyStimulus(2'b10, 6'b100100, 32'hF0F000FF, 32'h0FF00F0F);
        @(negedge clk);
        checkOutput("and result", result, 32'h00F0000F);
        applyStimulus(2'b10, 6'b100101, 32'hF0F000FF, 32'h0FF00F0F);
        @(negedge clk);
        checkOutput("or result", result, 32'hFFF00FFF);
        applyStimulus(2'b11, 6'b111111, 32'h12345678, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("illegal flag", illegal, 1);
        checkOutput("illegal result", result, 0);
        checkOutput("illegal zero", zero, 1);
        @(negedge clk);
        checkOutput("illegal held out_valid", out_valid, 0);
        checkOutput("illegal held", illegal, 1);

        applyStimulus(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7);
        waitCompletion(edges, sawReady);
        checkOutput("mult latency", edges, 34);
        checkOutput("mult in_ready low", sawReady, 0);
        checkOutput("mult result", result, 32'hFFFFFFEB);
        checkOutput("mult illegal cleared", illegal, 0);
        checkOutput("mult done in_ready", in_ready, 1);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("mfhi after mult", result, 32'hFFFFFFFF);
        applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mflo after mult", result, 32'hFFFFFFEB);

`ifdef ALU_DIV_EN
        applyStimulus(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
        waitCompletion(edges, sawReady);
        checkOutput("div latency", edges, 34);
        checkOutput("div result", result, 32'hFFFFFFFD);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("div remainder", result, 32'hFFFFFFFF);
        applyStimulus(2'b10, 6'b011011, 32'd9, 32'd0);
        @(negedge clk);
        checkOutput("divu0 out_valid", out_valid, 1);
        checkOutput("divu0 result", result, 32'hFFFFFFFF);
        checkOutput("divu0 div_zero", div_zero, 1);
        checkOutput("divu0 in_ready", in_ready, 1);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("divu0 hi", result, 32'd9);
        checkOutput("div_zero cleared", div_zero, 0);
        applyStimulus(2'b10, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
        waitCompletion(edges, sawReady);
        checkOutput("div min/-1 result", result, 32'h80000000);
        checkOutput("div min/-1 overflow", overflow, 0);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("div min/-1 hi", result, 32'h0);
`else
        applyStimulus(2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
        @(negedge clk);
        checkOutput("nodiv out_valid", out_valid, 1);
        checkOutput("nodiv illegal", illegal, 1);
        checkOutput("nodiv result", result, 0);
        checkOutput("nodiv in_ready", in_ready, 1);
        checkOutput("nodiv div_zero", div_zero, 0);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("nodiv hi unchanged", result, 32'hFFFFFFFF);
`endif

        @(negedge clk);
        applyStimulus(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("mid-mult in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst mid-op in_ready", in_ready, 1);
        checkOutput("rst mid-op out_valid", out_valid, 0);
        sawLate = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) sawLate = 1'b1;
        end
        checkOutput("no late out_valid", sawLate, 0);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst hi cleared", result, 0);
        applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rst lo cleared", result, 0);
        checkOutput("rst lo zero flag", zero, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
